bcd_scan_display: RTL and testbench

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. Latches a packed multi-digit BCD word, scans one digit at a time at a programmable refresh rate, and decodes each digit to the team's active-low segment pattern. Optional leading-zero blanking and per-digit decimal points. Sits between the datapath producing BCD results and the board's display pins.

---
 rtl/bcd_scan_display.sv | 152 +++++++++++++++
 tb/tb_bcd_scan_display.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed N-digit 7-segment driver.
// Holds a shadow copy of a packed BCD word and its decimal points, scans one
// digit per REFRESH_DIV clocks, and drives active-low segments through a
// registered output stage with optional leading-zero blanking.
module bcd_scan_display #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV      = 50000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING    = 1'b1,
    localparam int unsigned IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [NUM_DIGITS-1:0] ALL_ONES = {NUM_DIGITS{1'b1}};

    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [NUM_DIGITS-1:0]   digit_zero;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blank;

    // Active-low a..g pattern; codes 10..15 are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Shadow registers: the display only ever reads these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
        end else if (load) begin
            shadow_q    <= bcd_in;
            shadow_dp_q <= dp_in;
        end
    end

    // Prescaler and digit index next state; disable parks both at zero.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Current digit select plus leading-zero detection: zero_from[i] is set
    // when digit i and every digit above it are zero (invalid codes count as
    // non-zero).
    always_comb begin
        digit_zero = '0;
        zero_from  = '0;
        cur_bcd    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit_zero[i] = (shadow_q[4*i +: 4] == 4'd0);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_from[i] = ((digit_zero >> i) == (ALL_ONES >> i));
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd   = shadow_q[4*i +: 4];
                cur_dp    = shadow_dp_q[i];
                cur_blank = BLANK_LEADING && (i != 0) && zero_from[i];
            end
        end
    end

    // Output stage next state; anode polarity handled by XOR with the idle level.
    always_comb begin
        seg_d = '1;
        dp_d  = 1'b1;
        an_d  = AN_OFF;
        if (enable) begin
            seg_d = cur_blank ? 7'b1111111 : seg_decode(cur_bcd);
            dp_d  = ~cur_dp;
            an_d  = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
        end
    end

    // Registered outputs, one cycle behind index/shadow/enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '1;
            dp_q  <= 1'b1;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (4 digits, 4-cycle refresh, active-low
// anodes, leading-zero blanking). A digit-array model predicts each output
// word; a monitor compares after every clock edge.
module tb_bcd_scan_display;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    bcd_scan_display #(
        .NUM_DIGITS      (N),
        .REFRESH_DIV     (DIV),
        .ANODE_ACTIVE_LOW(1'b1),
        .BLANK_LEADING   (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .load     (load),
        .enable   (enable),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: displayed digits as integers and an enabled-cycle count.
    int m_dig[N];
    int m_dp[N];
    int m_cnt = 0;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t render(input int i);
        exp_t r;
        int   upper;
        upper = 0;
        for (int j = i; j < N; j++) upper += m_dig[j];
        r.seg   = (i > 0 && upper == 0) ? 7'b1111111 : seg_of(m_dig[i]);
        r.dp    = (m_dp[i] == 0);
        r.an    = 4'hF;
        r.an[i] = 1'b0;
        r.idx   = 2'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Reference model: predicts the output word produced by this edge.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            e.seg = 7'b1111111; e.dp = 1'b1; e.an = 4'hF; e.idx = 2'd0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_dp[i] = 0; end
        end else begin
            if (!enable) begin
                e.seg = 7'b1111111; e.dp = 1'b1; e.an = 4'hF;
                m_cnt = 0;
            end else begin
                e = render((m_cnt / DIV) % N);
                m_cnt++;
            end
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    m_dig[i] = int'((bcd_in >> (4*i)) & 16'hF);
                    m_dp[i]  = int'(dp_in[i]);
                end
            end
            e.idx = 2'((m_cnt / DIV) % N);
        end
        exp_q.push_back(e);
    end

    // Monitor: compares the DUT just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(dp), 32'(e.dp));
            check("an", 32'(an), 32'(e.an));
            check("digit_idx", 32'(digit_idx), 32'(e.idx));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        @(negedge clk);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] w;
        int r;
        w = '0;
        for (int i = 0; i < N; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 5)       w[4*i +: 4] = 4'd0;
            else if (r < 14) w[4*i +: 4] = 4'($urandom_range(1, 9));
            else             w[4*i +: 4] = 4'($urandom_range(10, 15));
        end
        return w;
    endfunction

    initial begin
        // reset held across a few edges
        wait_cyc(3);
        rst_n = 1'b1;

        // scan timing with 1234
        do_load(16'h1234, 4'b0000);
        @(negedge clk);
        enable = 1'b1;
        wait_cyc(41);

        // drop enable in the middle of digit 2, then restart
        enable = 1'b0;
        wait_cyc(3);
        enable = 1'b1;
        wait_cyc(20);

        // every code in digit 0
        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b0000);
            wait_cyc(16);
        end

        // leading-zero blanking patterns
        do_load(16'h0050, 4'b0000);
        wait_cyc(20);
        do_load(16'h0000, 4'b0000);
        wait_cyc(20);
        do_load(16'h0A00, 4'b0000);
        wait_cyc(20);

        // dp on digit 2 only, then bcd_in change without load
        do_load(16'h5678, 4'b0100);
        wait_cyc(20);
        bcd_in = 16'h9999;
        dp_in  = 4'b1111;
        wait_cyc(20);

        // randomized loads, dp, and enable toggles
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            bcd_in = rand_bcd();
            dp_in  = 4'($urandom_range(0, 15));
            load   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
        end
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
        wait_cyc(10);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'h1);
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_idx", 32'(digit_idx), 32'h0);
        wait_cyc(2);
        rst_n = 1'b1;
        do_load(16'h0907, 4'b0001);
        wait_cyc(20);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
